ram_port_arbiter: RTL and testbench

//  Shares the single RAM port between instruction fetch (port F, read-only) and the memory stage (port M, load/store).

---
 rtl/ram_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one toggle-triggered RAM port between instruction fetch (F, read-only) and the memory stage (M).
// Requests and RAM completion arrive as toggles and are synchronised; grants alternate when both ports wait.
module ram_port_arbiter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_req_tgl,
    input  logic        m_rw,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_ack_tgl,
    output logic [31:0] m_rdata,
    input  logic        f_req_tgl,
    input  logic [31:0] f_addr,
    output logic        f_ack_tgl,
    output logic [31:0] f_rdata,
    output logic        ram_trig,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_done_tgl,
    input  logic [31:0] ram_rdata,
    output logic        busy,
    output logic        grant_m,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] m_sync_q, m_sync_d;
    logic [SYNC_STAGES-1:0] f_sync_q, f_sync_d;
    logic [SYNC_STAGES-1:0] done_sync_q, done_sync_d;

    state_t      state_q, state_d;
    logic        m_seen_q, m_seen_d;
    logic        f_seen_q, f_seen_d;
    logic        done_seen_q, done_seen_d;
    logic        last_m_q, last_m_d;
    logic        orphan_q, orphan_d;
    logic [7:0]  timer_q, timer_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ram_trig_q, ram_trig_d;
    logic        ram_rw_q, ram_rw_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        m_ack_q, m_ack_d;
    logic        f_ack_q, f_ack_d;
    logic [31:0] m_rdata_q, m_rdata_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic        grant_m_q, grant_m_d;
    logic        timeout_err_q, timeout_err_d;

    logic m_sync, f_sync, done_sync;
    logic m_pend, f_pend, done_evt, pick_m;

    assign m_sync    = m_sync_q[SYNC_STAGES-1];
    assign f_sync    = f_sync_q[SYNC_STAGES-1];
    assign done_sync = done_sync_q[SYNC_STAGES-1];

    assign m_pend   = m_sync != m_seen_q;
    assign f_pend   = f_sync != f_seen_q;
    assign done_evt = done_sync != done_seen_q;

    // Synchronisers are deliberately not reset: the *_seen registers track them through reset.
    always_ff @(posedge clk) begin
        m_sync_q    <= m_sync_d;
        f_sync_q    <= f_sync_d;
        done_sync_q <= done_sync_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            m_seen_q      <= m_sync;
            f_seen_q      <= f_sync;
            done_seen_q   <= done_sync;
            last_m_q      <= 1'b0;
            orphan_q      <= 1'b0;
            timer_q       <= 8'd0;
            rdata_q       <= 32'd0;
            ram_trig_q    <= 1'b0;
            ram_rw_q      <= 1'b0;
            ram_addr_q    <= 32'd0;
            ram_wdata_q   <= 32'd0;
            m_ack_q       <= 1'b0;
            f_ack_q       <= 1'b0;
            m_rdata_q     <= 32'd0;
            f_rdata_q     <= 32'd0;
            grant_m_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            m_seen_q      <= m_seen_d;
            f_seen_q      <= f_seen_d;
            done_seen_q   <= done_seen_d;
            last_m_q      <= last_m_d;
            orphan_q      <= orphan_d;
            timer_q       <= timer_d;
            rdata_q       <= rdata_d;
            ram_trig_q    <= ram_trig_d;
            ram_rw_q      <= ram_rw_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            m_ack_q       <= m_ack_d;
            f_ack_q       <= f_ack_d;
            m_rdata_q     <= m_rdata_d;
            f_rdata_q     <= f_rdata_d;
            grant_m_q     <= grant_m_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        m_sync_d      = {m_sync_q[SYNC_STAGES-2:0], m_req_tgl};
        f_sync_d      = {f_sync_q[SYNC_STAGES-2:0], f_req_tgl};
        done_sync_d   = {done_sync_q[SYNC_STAGES-2:0], ram_done_tgl};
        state_d       = state_q;
        m_seen_d      = m_seen_q;
        f_seen_d      = f_seen_q;
        done_seen_d   = done_seen_q;
        last_m_d      = last_m_q;
        orphan_d      = orphan_q;
        timer_d       = timer_q;
        rdata_d       = rdata_q;
        ram_trig_d    = ram_trig_q;
        ram_rw_d      = ram_rw_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        m_ack_d       = m_ack_q;
        f_ack_d       = f_ack_q;
        m_rdata_d     = m_rdata_q;
        f_rdata_d     = f_rdata_q;
        grant_m_d     = grant_m_q;
        timeout_err_d = timeout_err_q;
        pick_m        = m_pend && (!f_pend || !last_m_q);

        // A completion for an abandoned access is swallowed whatever the state.
        if (orphan_q && done_evt) begin
            done_seen_d = done_sync;
            orphan_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!orphan_q && (m_pend || f_pend)) begin
                    grant_m_d   = pick_m;
                    last_m_d    = pick_m;
                    ram_rw_d    = pick_m ? m_rw : 1'b0;
                    ram_addr_d  = pick_m ? m_addr : f_addr;
                    ram_wdata_d = pick_m ? m_wdata : 32'd0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                ram_trig_d = ~ram_trig_q;
                timer_d    = 8'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (done_evt) begin
                    done_seen_d = done_sync;
                    if (!ram_rw_q) begin
                        rdata_d = ram_rdata;
                    end
                    state_d = RESP;
                end else if (timer_q == TMO_LIMIT) begin
                    timeout_err_d = 1'b1;
                    orphan_d      = 1'b1;
                    rdata_d       = ERR_DATA;
                    state_d       = RESP;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESP: begin
                if (grant_m_q) begin
                    m_ack_d  = ~m_ack_q;
                    m_seen_d = ~m_seen_q;
                    if (!ram_rw_q) begin
                        m_rdata_d = rdata_q;
                    end
                end else begin
                    f_ack_d   = ~f_ack_q;
                    f_seen_d  = ~f_seen_q;
                    f_rdata_d = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_ack_tgl   = m_ack_q;
    assign f_ack_tgl   = f_ack_q;
    assign m_rdata     = m_rdata_q;
    assign f_rdata     = f_rdata_q;
    assign ram_trig    = ram_trig_q;
    assign ram_rw      = ram_rw_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign busy        = state_q != IDLE;
    assign grant_m     = grant_m_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a toggle-protocol RAM responder plus a transaction-level
// reference model (memory image, serve order, held read data) checked with immediate assertions.
module tb_ram_port_arbiter;
    localparam time CLK_P       = 10;
    localparam int  LAT         = 4;
    localparam int  TIMEOUT_CYC = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req_tgl, m_rw, m_ack_tgl, f_req_tgl, f_ack_tgl;
    logic [31:0] m_addr, m_wdata, m_rdata, f_addr, f_rdata;
    logic        ram_trig, ram_rw, ram_done_tgl, busy, grant_m, timeout_err;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int checks = 0;
    int failures = 0;

    // RAM responder controls and logs
    int          ram_delay = 1;
    bit          ram_silent = 0;
    int          late_req_cnt = 0;
    int          late_ack_cnt;
    int          trig_count;
    int          overlap_cnt;
    logic [64:0] acc_log [256];
    logic [31:0] ram_mem [logic [31:0]];
    time         t_trig, t_done;

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    logic [64:0] exp_acc_q [$];
    int          rd_idx = 0;
    bit          last_m, tmo_model;
    logic        m_ack_model, f_ack_model;
    logic [31:0] m_rdata_model, f_rdata_model;
    time         t_req, t_m_ack, t_f_ack;

    always #(CLK_P / 2) clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m_req_tgl(m_req_tgl), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack_tgl(m_ack_tgl), .m_rdata(m_rdata),
        .f_req_tgl(f_req_tgl), .f_addr(f_addr), .f_ack_tgl(f_ack_tgl), .f_rdata(f_rdata),
        .ram_trig(ram_trig), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_done_tgl(ram_done_tgl), .ram_rdata(ram_rdata),
        .busy(busy), .grant_m(grant_m), .timeout_err(timeout_err)
    );

    // Contents of never-written RAM locations
    function automatic logic [31:0] bg_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : bg_word(a);
    endfunction

    // Toggle-protocol RAM: answers each trigger after ram_delay cycles unless silent.
    initial begin : ram_model
        int          rsp_cnt;
        logic        trig_seen;
        logic        p_rw;
        logic [31:0] p_addr, p_wdata;
        rsp_cnt = 0; trig_seen = 1'b0; trig_count = 0; overlap_cnt = 0; late_ack_cnt = 0;
        p_rw = 1'b0; p_addr = 32'd0; p_wdata = 32'd0;
        ram_done_tgl = 1'b0; ram_rdata = 32'd0;
        ram_mem[32'h100] = 32'h1234_5678;
        forever begin
            @(negedge clk);
            if (reset) begin
                rsp_cnt = 0;
                trig_seen = ram_trig;
            end else begin
                if (late_req_cnt != late_ack_cnt) begin
                    late_ack_cnt++;
                    ram_rdata = 32'hBAD0_0BAD;
                    ram_done_tgl = ~ram_done_tgl;
                    t_done = $time;
                end
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        if (p_rw) begin
                            ram_mem[p_addr] = p_wdata;
                            ram_rdata = ~p_wdata;
                        end else begin
                            ram_rdata = ram_mem.exists(p_addr) ? ram_mem[p_addr] : bg_word(p_addr);
                        end
                        ram_done_tgl = ~ram_done_tgl;
                        t_done = $time;
                    end
                end
                if (ram_trig !== trig_seen) begin
                    trig_seen = ram_trig;
                    if (rsp_cnt != 0) overlap_cnt++;
                    acc_log[trig_count[7:0]] = {ram_rw, ram_addr, ram_wdata};
                    trig_count++;
                    t_trig = $time;
                    p_rw = ram_rw; p_addr = ram_addr; p_wdata = ram_wdata;
                    rsp_cnt = ram_silent ? 0 : ram_delay;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_accesses();
        logic [64:0] e, a;
        while (exp_acc_q.size() > 0) begin
            e = exp_acc_q.pop_front();
            chk("acc_present", 64'(rd_idx < trig_count), 64'(1));
            if (rd_idx < trig_count) begin
                a = acc_log[rd_idx[7:0]];
                rd_idx++;
                chk("acc_rw_addr", 64'(a[64:32]), 64'(e[64:32]));
                if (e[64]) chk("acc_wdata", 64'(a[31:0]), 64'(e[31:0]));
            end
        end
        chk("acc_no_extra", 64'(trig_count - rd_idx), 64'(0));
    endtask

    task automatic model_m(input bit rw, input logic [31:0] a, input logic [31:0] wd,
                           inout logic [31:0] exp_rd);
        exp_acc_q.push_back({rw, a, wd});
        if (rw) ref_mem[a] = wd;
        else exp_rd = ref_read(a);
        last_m = 1'b1;
    endtask

    task automatic model_f(input logic [31:0] a, inout logic [31:0] exp_rd);
        exp_acc_q.push_back({1'b0, a, 32'h0});
        exp_rd = ref_read(a);
        last_m = 1'b0;
    endtask

    // Toggle the selected requests in one cycle, then collect and check both acks.
    task automatic run_pair(input bit do_m, input bit mrw, input logic [31:0] ma,
                            input logic [31:0] mwd, input bit do_f, input logic [31:0] fa);
        bit          m_first, got_m, got_f;
        logic [31:0] m_exp, f_exp;
        int          cyc;
        m_exp = m_rdata_model;
        f_exp = f_rdata_model;
        m_first = do_m && (!do_f || !last_m);
        if (m_first) begin
            model_m(mrw, ma, mwd, m_exp);
            if (do_f) model_f(fa, f_exp);
        end else begin
            if (do_f) model_f(fa, f_exp);
            if (do_m) model_m(mrw, ma, mwd, m_exp);
        end
        @(negedge clk);
        if (do_m) begin m_rw = mrw; m_addr = ma; m_wdata = mwd; m_req_tgl = ~m_req_tgl; end
        if (do_f) begin f_addr = fa; f_req_tgl = ~f_req_tgl; end
        t_req = $time;
        got_m = !do_m; got_f = !do_f; cyc = 0;
        while (!(got_m && got_f) && cyc < 120) begin
            @(negedge clk);
            cyc++;
            if (!got_m && m_ack_tgl !== m_ack_model) begin
                got_m = 1'b1; t_m_ack = $time; m_ack_model = ~m_ack_model;
                chk("m_rdata_at_ack", 64'(m_rdata), 64'(m_exp));
                m_rdata_model = m_exp;
            end
            if (!got_f && f_ack_tgl !== f_ack_model) begin
                got_f = 1'b1; t_f_ack = $time; f_ack_model = ~f_ack_model;
                chk("f_rdata_at_ack", 64'(f_rdata), 64'(f_exp));
                f_rdata_model = f_exp;
            end
        end
        if (do_m) chk("m_ack_arrived", 64'(got_m), 64'(1));
        if (do_f) chk("f_ack_arrived", 64'(got_f), 64'(1));
        repeat (3) @(negedge clk);
        chk("m_ack_parity", 64'(m_ack_tgl), 64'(m_ack_model));
        chk("f_ack_parity", 64'(f_ack_tgl), 64'(f_ack_model));
        chk("m_rdata_held", 64'(m_rdata), 64'(m_rdata_model));
        chk("f_rdata_held", 64'(f_rdata), 64'(f_rdata_model));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("grant_m", 64'(grant_m), 64'(last_m));
        chk("timeout_err", 64'(timeout_err), 64'(tmo_model));
        chk("trig_overlap", 64'(overlap_cnt), 64'(0));
        check_accesses();
    endtask

    // Reset the DUT and the requesters together; check cleared outputs and a quiet release.
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; m_req_tgl = 1'b0; f_req_tgl = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst_ctrl_outputs", 64'({m_ack_tgl, f_ack_tgl, ram_trig, ram_rw, busy, grant_m, timeout_err}), 64'(0));
        chk("rst_m_rdata", 64'(m_rdata), 64'(0));
        chk("rst_f_rdata", 64'(f_rdata), 64'(0));
        chk("rst_ram_addr", 64'(ram_addr), 64'(0));
        chk("rst_ram_wdata", 64'(ram_wdata), 64'(0));
        m_ack_model = 1'b0; f_ack_model = 1'b0;
        m_rdata_model = 32'd0; f_rdata_model = 32'd0;
        last_m = 1'b0; tmo_model = 1'b0;
        exp_acc_q.delete();
        rd_idx = trig_count;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_acks", 64'({m_ack_tgl, f_ack_tgl}), 64'(0));
        chk("post_rst_no_trig", 64'(trig_count - rd_idx), 64'(0));
    endtask

    initial begin : main
        int   cyc;
        logic trig_prev;
        reset = 1'b1; m_req_tgl = 1'b0; m_rw = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
        f_req_tgl = 1'b0; f_addr = 32'd0;
        ref_mem[32'h100] = 32'h1234_5678;
        do_reset(5);

        // Single M load, RAM answers after 5 cycles; both latencies are SYNC_STAGES+2
        ram_delay = 5;
        run_pair(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        chk("t1_req_to_trig", 64'(t_trig - t_req), 64'(LAT * CLK_P));
        chk("t1_done_to_ack", 64'(t_m_ack - t_done), 64'(LAT * CLK_P));

        // M store: ack must follow the RAM completion
        ram_delay = 8;
        run_pair(1'b1, 1'b1, 32'h40, 32'h0000_CAFE, 1'b0, 32'h0);
        chk("t2_done_to_ack", 64'(t_m_ack - t_done), 64'(LAT * CLK_P));

        // Simultaneous pairs after reset alternate M, F, M, F ...
        do_reset(4);
        ram_delay = 2;
        for (int i = 0; i < 4; i++) begin
            run_pair(1'b1, 1'b0, 32'h200 + 32'($urandom_range(0, 15) * 4), 32'h0,
                     1'b1, 32'($urandom_range(0, 15) * 4));
        end

        // F fetch with a silent RAM times out; the late completion is absorbed
        ram_silent = 1'b1;
        @(negedge clk);
        f_addr = 32'h300; f_req_tgl = ~f_req_tgl;
        exp_acc_q.push_back({1'b0, 32'h300, 32'h0});
        trig_prev = ram_trig; cyc = 0;
        while (ram_trig === trig_prev && cyc < 20) begin @(negedge clk); cyc++; end
        chk("t4_trig_issued", 64'(ram_trig !== trig_prev), 64'(1));
        chk("t4_no_err_yet", 64'(timeout_err), 64'(0));
        cyc = 0;
        while (f_ack_tgl === f_ack_model && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 100) chk("t4_busy_in_wait", 64'(busy), 64'(1));
        end
        chk("t4_timeout_window", 64'(cyc >= TIMEOUT_CYC && cyc <= TIMEOUT_CYC + 4), 64'(1));
        chk("t4_f_rdata_err", 64'(f_rdata), 64'(32'hDEAD_BEEF));
        chk("t4_timeout_err", 64'(timeout_err), 64'(1));
        f_ack_model = ~f_ack_model; f_rdata_model = 32'hDEAD_BEEF; last_m = 1'b0; tmo_model = 1'b1;
        repeat (10) @(negedge clk);
        check_accesses();
        chk("t4_idle_while_orphan", 64'(busy), 64'(0));
        late_req_cnt++;
        ram_silent = 1'b0; ram_delay = 3;
        repeat (8) @(negedge clk);
        chk("t4_late_done_no_trig", 64'(trig_count - rd_idx), 64'(0));
        run_pair(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);

        // Reset while WAIT is outstanding: abandoned, no ack, no phantom request
        ram_silent = 1'b1;
        @(negedge clk);
        m_rw = 1'b0; m_addr = 32'h44; m_req_tgl = ~m_req_tgl;
        trig_prev = ram_trig; cyc = 0;
        while (ram_trig === trig_prev && cyc < 20) begin @(negedge clk); cyc++; end
        chk("t5_trig_issued", 64'(ram_trig !== trig_prev), 64'(1));
        repeat (5) @(negedge clk);
        chk("t5_busy_before_reset", 64'(busy), 64'(1));
        do_reset(4);
        ram_silent = 1'b0;

        // Eight back-to-back fetches against a 1-cycle RAM
        ram_delay = 1;
        for (int i = 0; i < 8; i++) begin
            run_pair(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'($urandom_range(0, 31) * 4));
        end

        // Random mix of loads, stores and fetches with varying RAM latency
        for (int i = 0; i < 12; i++) begin
            bit dm, df;
            dm = 1'($urandom_range(0, 1));
            df = 1'($urandom_range(0, 1));
            if (!dm && !df) dm = 1'b1;
            ram_delay = int'($urandom_range(1, 6));
            run_pair(dm, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31) * 4), $urandom,
                     df, 32'($urandom_range(0, 31) * 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
